// File: rtl/bcd_pkg.sv
// bcd_pkg: shared digit type, stopwatch states and BCD helpers.
package bcd_pkg;
   typedef logic [3:0] bcd_t;
   typedef enum logic [1:0] {IDLE, RUN, STOP} sw_state_t;
   localparam bcd_t BCD_MAX = 4'd9;
   function automatic bcd_t bcd_inc(input bcd_t d, input logic c);
      return !c ? d : (d == BCD_MAX ? '0 : d + 4'd1);
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability filter and one-cycle press pulse for an active-low pin.
module btn_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);
   localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   logic [1:0] sync;
   logic lvl, flip;
   logic [CW-1:0] cnt;
   // accept the new level on the DEB_CYCLES-th consecutive differing sample
   assign flip = (sync[1] != lvl) && (cnt == CW'(DEB_CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         lvl   <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_n};
         cnt   <= (sync[1] == lvl || flip) ? '0 : cnt + CW'(1);
         lvl   <= flip ? sync[1] : lvl;
         press <= flip & lvl;
      end
   end
endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: 000.0-999.9 s BCD stopwatch with debounced start/stop and clear buttons.
// Define LAP_EN to let clear during RUN toggle a frozen lap display.
module bcd_stopwatch
   import bcd_pkg::*;
#(
   parameter int TICK_DIV   = 5000000,
   parameter int DEB_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_ss_n,
   input  logic       btn_clr_n,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic       running,
   output logic       ovf
);
   localparam int TW = $clog2(TICK_DIV);
   sw_state_t st, st_n;
   bcd_t [3:0] dig, dig_n, inc;
   logic [TW-1:0] tcnt, tcnt_n;
   logic ss_p, clr_p, tick, ovf_n, c1, c2, c3, all9;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ss  (.clk(clk), .rst_n(rst_n), .btn_n(btn_ss_n),  .press(ss_p));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (.clk(clk), .rst_n(rst_n), .btn_n(btn_clr_n), .press(clr_p));

   assign tick = st == RUN && tcnt == TW'(TICK_DIV - 1);
   assign c1   = dig[0] == BCD_MAX;
   assign c2   = c1 && dig[1] == BCD_MAX;
   assign c3   = c2 && dig[2] == BCD_MAX;
   assign all9 = c3 && dig[3] == BCD_MAX;
   assign inc  = {bcd_inc(dig[3], c3), bcd_inc(dig[2], c2), bcd_inc(dig[1], c1), bcd_inc(dig[0], 1'b1)};

   always_comb begin
      st_n   = st;
      dig_n  = dig;
      ovf_n  = ovf;
      tcnt_n = st == RUN ? (tick ? '0 : tcnt + TW'(1)) : (st == IDLE ? '0 : tcnt);
      case (st)
         IDLE: st_n = ss_p ? RUN : IDLE;
         RUN: begin
            if (tick && all9) begin
               ovf_n = 1'b1;
               st_n  = STOP;
            end else begin
               dig_n = tick ? inc : dig;
               st_n  = ss_p ? STOP : RUN;
            end
         end
         STOP: begin
            // a start press is ignored once overflowed, leaving clear to act
            if (ss_p && !ovf) st_n = RUN;
            else if (clr_p) begin
               st_n  = IDLE;
               dig_n = '0;
               ovf_n = 1'b0;
            end
         end
         default: st_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= IDLE;
         dig  <= '0;
         ovf  <= 1'b0;
         tcnt <= '0;
      end else begin
         st   <= st_n;
         dig  <= dig_n;
         ovf  <= ovf_n;
         tcnt <= tcnt_n;
      end
   end

   assign running = st == RUN;

`ifdef LAP_EN
   logic lap;
   bcd_t [3:0] snap;
   // hold only survives while staying in RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap  <= 1'b0;
         snap <= '0;
      end else begin
         lap <= st == RUN && st_n == RUN && (lap ^ clr_p);
         if (st == RUN && clr_p && !lap) snap <= dig;
      end
   end
   assign {d3, d2, d1, d0} = lap ? snap : dig;
`else
   assign {d3, d2, d1, d0} = dig;
`endif
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed self-checking bench, TICK_DIV=4, DEB_CYCLES=3.
module tb_bcd_stopwatch;
   logic clk = 1'b0, rst_n = 1'b0, btn_ss_n = 1'b1, btn_clr_n = 1'b1;
   logic [3:0] d3, d2, d1, d0;
   logic running, ovf;
   logic [15:0] dg;
   int checks = 0, errors = 0;

   bcd_stopwatch #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n), .btn_ss_n(btn_ss_n), .btn_clr_n(btn_clr_n),
      .d3(d3), .d2(d2), .d1(d1), .d0(d0), .running(running), .ovf(ovf));

   assign dg = {d3, d2, d1, d0};
   always #5 clk = ~clk;

   // hold the chosen buttons low until the accepted press has changed state
   task automatic press(input logic ss, input logic clr);
      btn_ss_n  = ~ss;
      btn_clr_n = ~clr;
      repeat (6) @(negedge clk);
      btn_ss_n  = 1'b1;
      btn_clr_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (dg !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_init: digits=%h run=%b ovf=%b want 0000/0/0", dg, running, ovf); end
      rst_n = 1'b1;
      @(negedge clk);
      press(1, 0);
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_start: run=%b want 1", running); end
      repeat (10) @(negedge clk);
      checks++; if (dg !== 16'h0002) begin errors++; $display("FAIL reset_precount: digits=%h want 0002", dg); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (dg !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_async: digits=%h run=%b ovf=%b want 0000/0/0", dg, running, ovf); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_debounce();
      int n;
      for (int i = 0; i < 10; i++) begin
         btn_ss_n = i[0];
         @(negedge clk);
      end
      btn_ss_n = 1'b0;
      n = 0;
      while (!running && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n < 5 || n > 6) begin errors++; $display("FAIL deb_latency: cycles=%0d want 5..6", n); end
      repeat (15) @(negedge clk);
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL deb_single: run=%b want 1", running); end
      btn_ss_n = 1'b1;
      repeat (6) @(negedge clk);
      press(1, 0);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL deb_stop: run=%b want 0", running); end
      repeat (6) @(negedge clk);
      btn_ss_n = 1'b0;
      repeat (2) @(negedge clk);
      btn_ss_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL deb_glitch: run=%b want 0", running); end
      press(0, 1);
      checks++; if (dg !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL deb_clear: digits=%h run=%b ovf=%b want 0000/0/0", dg, running, ovf); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_counting();
      press(1, 0);
      checks++; if (dg !== 16'h0000 || running !== 1'b1) begin errors++; $display("FAIL cnt_start: digits=%h run=%b want 0000/1", dg, running); end
      repeat (44) @(negedge clk);
      press(1, 0);
      checks++; if (dg !== 16'h0012 || running !== 1'b0) begin errors++; $display("FAIL cnt_12: digits=%h run=%b want 0012/0", dg, running); end
      repeat (100) @(negedge clk);
      checks++; if (dg !== 16'h0012 || running !== 1'b0) begin errors++; $display("FAIL cnt_hold: digits=%h run=%b want 0012/0", dg, running); end
      press(1, 0);
      checks++; if (dg !== 16'h0012 || running !== 1'b1) begin errors++; $display("FAIL cnt_resume: digits=%h run=%b want 0012/1", dg, running); end
      @(negedge clk);
      checks++; if (dg !== 16'h0012) begin errors++; $display("FAIL cnt_frac1: digits=%h want 0012", dg); end
      @(negedge clk);
      checks++; if (dg !== 16'h0013) begin errors++; $display("FAIL cnt_frac2: digits=%h want 0013", dg); end
   endtask

   task automatic test_carry();
      int n = 0;
      while (dg !== 16'h0099 && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++; if (dg !== 16'h0099) begin errors++; $display("FAIL carry_reach: digits=%h want 0099", dg); end
      n = 0;
      while (dg === 16'h0099 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++; if (dg !== 16'h0100) begin errors++; $display("FAIL carry_ripple: digits=%h want 0100", dg); end
      press(1, 0);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL carry_stop: run=%b want 0", running); end
   endtask

   task automatic test_overflow();
      int n = 0;
      force dut.dig = 16'h9998;
      @(negedge clk);
      release dut.dig;
      @(negedge clk);
      checks++; if (dg !== 16'h9998 || running !== 1'b0) begin errors++; $display("FAIL ovf_preload: digits=%h run=%b want 9998/0", dg, running); end
      repeat (6) @(negedge clk);
      press(1, 0);
      while (!ovf && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (dg !== 16'h9999 || ovf !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL ovf_set: digits=%h ovf=%b run=%b want 9999/1/0", dg, ovf, running); end
      repeat (6) @(negedge clk);
      press(1, 0);
      repeat (4) @(negedge clk);
      checks++; if (dg !== 16'h9999 || ovf !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL ovf_ss_ignored: digits=%h ovf=%b run=%b want 9999/1/0", dg, ovf, running); end
      repeat (6) @(negedge clk);
      press(0, 1);
      checks++; if (dg !== 16'h0000 || ovf !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL ovf_clear: digits=%h ovf=%b run=%b want 0000/0/0", dg, ovf, running); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_priority();
      press(1, 0);
      repeat (16) @(negedge clk);
      press(1, 0);
      checks++; if (dg !== 16'h0005 || running !== 1'b0) begin errors++; $display("FAIL prio_stop5: digits=%h run=%b want 0005/0", dg, running); end
      repeat (6) @(negedge clk);
      press(1, 1);
      checks++; if (dg !== 16'h0005 || running !== 1'b1) begin errors++; $display("FAIL prio_both: digits=%h run=%b want 0005/1", dg, running); end
      repeat (6) @(negedge clk);
      press(0, 1);
      checks++; if (dg !== 16'h0008 || running !== 1'b1) begin errors++; $display("FAIL clr_run: digits=%h run=%b want 0008/1", dg, running); end
      repeat (2) @(negedge clk);
`ifdef LAP_EN
      checks++; if (dg !== 16'h0008) begin errors++; $display("FAIL lap_frozen: digits=%h want 0008", dg); end
      checks++; if (dut.dig !== 16'h0009) begin errors++; $display("FAIL lap_internal: count=%h want 0009", dut.dig); end
`else
      checks++; if (dg !== 16'h0009) begin errors++; $display("FAIL clr_ignored: digits=%h want 0009", dg); end
`endif
      repeat (6) @(negedge clk);
      press(0, 1);
      checks++; if (dg !== 16'h0012 || running !== 1'b1) begin errors++; $display("FAIL clr_second: digits=%h run=%b want 0012/1", dg, running); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_counting();
      test_carry();
      test_overflow();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Upstream digit source for the 4-digit multiplexed seven-segment driver (ss_cntr). Implements a 000.0–999.9 s decimal stopwatch with debounced start/stop and clear buttons. Produces four 4-bit BCD digits that connect directly to the driver's four digit inputs, MSD first.

Parameters:
TICK_DIV, 5000000, clk cycles per 0.1 s count tick (50 MHz clk); legal range ≥ 2
DEB_CYCLES, 500000, clk cycles a synchronized button level must stay stable before it is accepted (10 ms); legal range ≥ 1

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
btn_ss_n  input  1  start/stop button, active-low, asynchronous raw pin
btn_clr_n  input  1  clear button, active-low, asynchronous raw pin
d3  output  4  hundreds-of-seconds BCD digit
d2  output  4  tens-of-seconds BCD digit
d1  output  4  seconds BCD digit
d0  output  4  tenths BCD digit
running  output  1  high in RUN state
ovf  output  1  sticky overflow flag

Behaviour:
- Reset (rst_n=0, async): state=IDLE; d3..d0=0; running=0; ovf=0; tick counter=0; debouncers reset to released (level 1).
- Buttons: each pin goes through a 2-FF synchronizer, then a stability counter. The accepted level updates after DEB_CYCLES consecutive equal samples. A 1→0 transition of the accepted level gives a single-cycle press pulse (ss_p, clr_p). Press-pulse latency from a stable pin edge: 2 + DEB_CYCLES cycles, ±1.
- FSM states: IDLE, RUN, STOP.
  - IDLE: ss_p → RUN, tick counter cleared to 0. clr_p → stay IDLE.
  - RUN: ss_p → STOP. clr_p is ignored (see Optional Feature).
  - STOP: ss_p → RUN, tick counter kept, so the fraction resumes. clr_p → IDLE with digits=0 and ovf=0.
  - Same-cycle ss_p and clr_p: ss_p wins and clr_p is dropped.
- Tick counter: counts 0..TICK_DIV-1 only in RUN and holds otherwise. tick=1 for the single cycle where the count equals TICK_DIV-1, and the counter wraps to 0.
- BCD increment on tick:
  - d0 increments and wraps 9→0 with a carry into d1.
  - The carry ripples the same way through d1 and d2 into d3, all combinationally in the same cycle.
  - Digits never leave 0..9.
- Overflow: a tick at 9,9,9,9 leaves the digits at 9999, sets ovf=1 and forces state STOP.
  - ovf is sticky and is cleared only by clr_p in STOP or by reset.
  - ss_p in STOP with ovf=1 is ignored.
- Tick and ss_p in the same RUN cycle: the increment is applied and the state goes to STOP.
- Outputs are registered. Digits update 1 cycle after tick. running follows the state register.

Optional Feature:
Macro LAP_EN.
- Defined: clr_p in RUN toggles a lap-hold bit.
  - While lap-hold=1, d3..d0 show a snapshot latched at the press; the internal count keeps running.
  - A second clr_p in RUN releases the hold and the live value shows on the next cycle.
  - Leaving RUN (ss_p or overflow) releases the hold, so the outputs show the live value.
- Not defined: clr_p in RUN is ignored, there is no snapshot register, and outputs always show the live count.

Decomposition:
- Package bcd_pkg holds:
  - typedef bcd_t (logic [3:0])
  - enum sw_state_t {IDLE, RUN, STOP}
  - constant BCD_MAX = 4'd9
- Sub-module btn_debounce #(DEB_CYCLES) handles synchronizer, stability counter and press pulse. It is instantiated twice.
- FSM, tick divider and BCD chain stay in bcd_stopwatch.

Test Plan:
All scenarios use TICK_DIV=4 and DEB_CYCLES=3.
- Reset: rst_n pulsed low mid-count → asynchronously d3..d0=0,0,0,0, running=0, ovf=0, state IDLE.
- Debounce: btn_ss_n toggles every cycle for 10 cycles, then held low → exactly one ss_p, running=1 about 5–6 cycles after the hold starts. A 2-cycle glitch → no press.
- Counting: start, run 48 clk cycles → 12 ticks → digits 0,0,1,2. Stop, wait 100 cycles → unchanged. Restart → next tick after the remaining fraction only.
- Carry ripple: preload by running to 0,0,9,9 then one tick → 0,1,0,0 in one step.
- Overflow: reach 9,9,9,9 then one more tick → digits hold 9999, ovf=1, running=0. ss press ignored. clr press → 0,0,0,0, ovf=0, IDLE.
- Priority/clear: both buttons pressed the same cycle in STOP → RUN, digits kept. clr in RUN with LAP_EN undefined → no effect. With LAP_EN, clr in RUN at 0,0,0,5 → outputs frozen at 0,0,0,5 while the internal count advances. Second clr → live value.
